extmem_store: RTL and testbench

// - On-chip model/backing store for the accelerator's external memory, sitting directly downstream of
//   the controller's extmem interface.
// - Serves controller MEM_LOAD reads (fixed 1-cycle latency) and MEM_SAVE writes.
// - Also provides a host preload port: streamed 32-bit beats, each unpacked into two 16-bit words.

---
 rtl/extmem_store.sv | 131 +++++++++++++
 tb/tb_extmem_store.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/extmem_store.sv
// Backing store for the accelerator's external memory: 1R1W word array serving
// controller loads/stores, plus a host preload port that unpacks 32-bit beats into two words.
module extmem_store #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int HOST_W = 2 * DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctl_re,
  input  logic [ADDR_W-1:0] ctl_rd_addr,
  output logic [DATA_W-1:0] ctl_rd_data,
  input  logic              ctl_we,
  input  logic [ADDR_W-1:0] ctl_wr_addr,
  input  logic [DATA_W-1:0] ctl_wr_data,
  input  logic              host_start,
  input  logic [ADDR_W-1:0] host_base,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [HOST_W-1:0] host_data,
  input  logic              host_last,
  output logic              host_busy,
  output logic              host_done,
  output logic [ADDR_W:0]   host_wcount
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCEPT = 2'd1;
  localparam logic [1:0] WR_LO  = 2'd2;
  localparam logic [1:0] WR_HI  = 2'd3;

  localparam logic [ADDR_W:0] WC_MAX = {1'b1, {ADDR_W{1'b0}}};

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [HOST_W-1:0] beat;
  logic              beat_last;
  logic              host_we;
  logic [DATA_W-1:0] host_wdata;

  // Host handshake: a beat transfers on a rising clk edge where host_valid && host_ready;
  // host_ready depends only on state, never combinationally on host_valid.
  assign host_ready = (state == ACCEPT);
  assign host_busy  = (state != IDLE);

  // Controller writes own the single write port; the host word waits whenever ctl_we is high.
  always_comb begin
    host_we    = 1'b0;
    host_wdata = beat[DATA_W-1:0];
    if (!ctl_we) begin
      if (state == WR_LO) begin
        host_we    = 1'b1;
        host_wdata = beat[DATA_W-1:0];
      end else if (state == WR_HI) begin
        host_we    = 1'b1;
        host_wdata = beat[HOST_W-1:DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ctl_we) begin
      mem[ctl_wr_addr] <= ctl_wr_data;
    end else if (host_we) begin
      mem[ptr] <= host_wdata;
    end
  end

  // Read-first: the array read samples the value before this edge's write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_rd_data <= '0;
    end else if (ctl_re) begin
      ctl_rd_data <= mem[ctl_rd_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      beat        <= '0;
      beat_last   <= 1'b0;
      host_wcount <= '0;
      host_done   <= 1'b0;
    end else begin
      host_done <= 1'b0;
      case (state)
        IDLE: begin
          if (host_start) begin
            ptr         <= host_base;
            host_wcount <= '0;
            state       <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (host_valid) begin
            beat      <= host_data;
            beat_last <= host_last;
            state     <= WR_LO;
          end
        end
        WR_LO: begin
          if (host_we) begin
            ptr <= ptr + 1'b1;
            if (host_wcount != WC_MAX) host_wcount <= host_wcount + 1'b1;
            state <= WR_HI;
          end
        end
        WR_HI: begin
          if (host_we) begin
            ptr <= ptr + 1'b1;
            if (host_wcount != WC_MAX) host_wcount <= host_wcount + 1'b1;
            if (beat_last) begin
              host_done <= 1'b1;
              state     <= IDLE;
            end else begin
              state <= ACCEPT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_extmem_store.sv
// Directed bench for extmem_store: read latency/hold, host bursts, write contention,
// read-first collision, pointer wrap and reset in the middle of a burst.
module tb_extmem_store;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int HOST_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ctl_re = 1'b0;
  logic [ADDR_W-1:0] ctl_rd_addr = '0;
  logic [DATA_W-1:0] ctl_rd_data;
  logic              ctl_we = 1'b0;
  logic [ADDR_W-1:0] ctl_wr_addr = '0;
  logic [DATA_W-1:0] ctl_wr_data = '0;
  logic              host_start = 1'b0;
  logic [ADDR_W-1:0] host_base = '0;
  logic              host_valid = 1'b0;
  logic              host_ready;
  logic [HOST_W-1:0] host_data = '0;
  logic              host_last = 1'b0;
  logic              host_busy;
  logic              host_done;
  logic [ADDR_W:0]   host_wcount;

  int n_checks = 0;
  int n_errors = 0;

  extmem_store #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HOST_W(HOST_W)) dut (
    .clk(clk), .rst(rst),
    .ctl_re(ctl_re), .ctl_rd_addr(ctl_rd_addr), .ctl_rd_data(ctl_rd_data),
    .ctl_we(ctl_we), .ctl_wr_addr(ctl_wr_addr), .ctl_wr_data(ctl_wr_data),
    .host_start(host_start), .host_base(host_base),
    .host_valid(host_valid), .host_ready(host_ready), .host_data(host_data),
    .host_last(host_last), .host_busy(host_busy), .host_done(host_done),
    .host_wcount(host_wcount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All driver tasks start and end on a falling edge.
  task automatic ctl_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ctl_we = 1'b1; ctl_wr_addr = a; ctl_wr_data = d;
    @(negedge clk);
    ctl_we = 1'b0;
  endtask

  task automatic ctl_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
    ctl_re = 1'b1; ctl_rd_addr = a;
    @(negedge clk);
    ctl_re = 1'b0;
    d = ctl_rd_data;
  endtask

  task automatic start_burst(input logic [ADDR_W-1:0] b);
    host_start = 1'b1; host_base = b;
    @(negedge clk);
    host_start = 1'b0;
  endtask

  task automatic send_beat(input logic [HOST_W-1:0] d, input logic l);
    int waited = 0;
    while (!host_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!host_ready) check("beat_ready_timeout", 32'd0, 32'd1);
    host_valid = 1'b1; host_data = d; host_last = l;
    @(negedge clk);
    host_valid = 1'b0; host_last = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int waited = 0;
    while (!host_done && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_done_seen"}, {31'd0, host_done}, 32'd1);
    check({tag, "_busy_at_done"}, {31'd0, host_busy}, 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse_1cyc"}, {31'd0, host_done}, 32'd0);
  endtask

  initial begin
    logic [DATA_W-1:0] rd;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rd_data", {16'd0, ctl_rd_data}, 32'd0);
    check("rst_ready", {31'd0, host_ready}, 32'd0);
    check("rst_busy", {31'd0, host_busy}, 32'd0);
    check("rst_done", {31'd0, host_done}, 32'd0);
    check("rst_wcount", {15'd0, host_wcount}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Read latency and hold
    ctl_write(16'd5, 16'hABCD);
    ctl_read(16'd5, rd);
    check("rd_latency", {16'd0, rd}, 32'h0000ABCD);
    ctl_rd_addr = 16'd9;
    repeat (3) @(negedge clk);
    check("rd_hold", {16'd0, ctl_rd_data}, 32'h0000ABCD);

    // host_valid outside a burst is ignored
    host_valid = 1'b1; host_data = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    host_valid = 1'b0;
    check("idle_valid_busy", {31'd0, host_busy}, 32'd0);
    check("idle_valid_wcount", {15'd0, host_wcount}, 32'd0);

    // Two-beat burst, with a host_start during the burst that must be ignored
    start_burst(16'h0100);
    check("burst_ready", {31'd0, host_ready}, 32'd1);
    check("burst_busy", {31'd0, host_busy}, 32'd1);
    send_beat(32'h22221111, 1'b0);
    host_start = 1'b1; host_base = 16'h0800;
    @(negedge clk);
    host_start = 1'b0;
    send_beat(32'h44443333, 1'b1);
    wait_done("burst");
    check("burst_wcount", {15'd0, host_wcount}, 32'd4);
    ctl_read(16'h0100, rd); check("burst_m100", {16'd0, rd}, 32'h1111);
    ctl_read(16'h0101, rd); check("burst_m101", {16'd0, rd}, 32'h2222);
    ctl_read(16'h0102, rd); check("burst_m102", {16'd0, rd}, 32'h3333);
    ctl_read(16'h0103, rd); check("burst_m103", {16'd0, rd}, 32'h4444);
    ctl_read(16'h0800, rd); check("busy_start_ignored", {16'd0, rd}, 32'h0000);

    // Contention: ctl_we held 4 cycles while the host sits in WR_LO
    start_burst(16'h0200);
    send_beat(32'h66665555, 1'b1);
    for (int i = 0; i < 4; i++) begin
      ctl_we = 1'b1; ctl_wr_addr = 16'h0300 + 16'(i); ctl_wr_data = 16'h7770 + 16'(i);
      @(negedge clk);
      check($sformatf("cont_stall_%0d", i), {15'd0, host_wcount}, 32'd0);
    end
    ctl_we = 1'b0;
    @(negedge clk);
    check("cont_lo_after_stall", {15'd0, host_wcount}, 32'd1);
    wait_done("cont");
    check("cont_wcount", {15'd0, host_wcount}, 32'd2);
    ctl_read(16'h0200, rd); check("cont_m200", {16'd0, rd}, 32'h5555);
    ctl_read(16'h0201, rd); check("cont_m201", {16'd0, rd}, 32'h6666);
    for (int i = 0; i < 4; i++) begin
      ctl_read(16'h0300 + 16'(i), rd);
      check($sformatf("cont_ctl_%0d", i), {16'd0, rd}, 32'h7770 + i);
    end

    // Read-first collision
    ctl_write(16'd7, 16'h1234);
    ctl_we = 1'b1; ctl_wr_addr = 16'd7; ctl_wr_data = 16'h5555;
    ctl_re = 1'b1; ctl_rd_addr = 16'd7;
    @(negedge clk);
    ctl_we = 1'b0; ctl_re = 1'b0;
    check("rf_old", {16'd0, ctl_rd_data}, 32'h1234);
    ctl_read(16'd7, rd); check("rf_new", {16'd0, rd}, 32'h5555);

    // Pointer wrap
    start_burst(16'hFFFF);
    send_beat(32'hBBBBAAAA, 1'b1);
    wait_done("wrap");
    check("wrap_wcount", {15'd0, host_wcount}, 32'd2);
    ctl_read(16'hFFFF, rd); check("wrap_mffff", {16'd0, rd}, 32'hAAAA);
    ctl_read(16'h0000, rd); check("wrap_m0000", {16'd0, rd}, 32'hBBBB);

    // Reset during WR_HI
    ctl_write(16'h0401, 16'h9999);
    start_burst(16'h0400);
    send_beat(32'hDDDDCCCC, 1'b1);
    @(negedge clk);
    check("mid_wcount_lo", {15'd0, host_wcount}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_rd_data", {16'd0, ctl_rd_data}, 32'd0);
    check("mid_rst_ready", {31'd0, host_ready}, 32'd0);
    check("mid_rst_busy", {31'd0, host_busy}, 32'd0);
    check("mid_rst_done", {31'd0, host_done}, 32'd0);
    check("mid_rst_wcount", {15'd0, host_wcount}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_idle", {31'd0, host_busy}, 32'd0);
    ctl_read(16'h0400, rd); check("mid_lo_kept", {16'd0, rd}, 32'hCCCC);
    ctl_read(16'h0401, rd); check("mid_hi_dropped", {16'd0, rd}, 32'h9999);

    // New burst after reset
    start_burst(16'h0500);
    send_beat(32'hF00DCAFE, 1'b1);
    wait_done("post_rst");
    check("post_rst_wcount", {15'd0, host_wcount}, 32'd2);
    ctl_read(16'h0500, rd); check("post_rst_m500", {16'd0, rd}, 32'hCAFE);
    ctl_read(16'h0501, rd); check("post_rst_m501", {16'd0, rd}, 32'hF00D);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
